// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Holds the FSM state encoding, the requester port ids and the default widths.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector.
// A lone requester wins outright; on a tie the port that was not granted last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  // NOTE: every output gets a value on every path of an always_comb, otherwise a latch is inferred.
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 && req1) ? ~last_gnt : req1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 32-byte data memory between the CPU and DMA ports.
// Each grant runs IDLE/RESP -> ACCESS -> RESP; one word access per two cycles when busy.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic              last_gnt;
  logic              port;
  logic              lat_we;
  logic              lat_mis;

  logic              pick_valid;
  logic              pick_winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_aligned;

  rr_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_comb begin
    sel_we      = (pick_winner == PORT_DMA) ? we1    : we0;
    sel_addr    = (pick_winner == PORT_DMA) ? addr1  : addr0;
    sel_wdata   = (pick_winner == PORT_DMA) ? wdata1 : wdata0;
    sel_aligned = (sel_addr[1:0] == 2'b00);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the async reset clears every control register, so mem_en falls the instant rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= PORT_DMA;
      port      <= PORT_CPU;
      lat_we    <= 1'b0;
      lat_mis   <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Pulse outputs default low; the state case raises them for exactly one cycle.
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      err    <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (pick_valid) begin
            state     <= ACCESS;
            last_gnt  <= pick_winner;
            port      <= pick_winner;
            lat_we    <= sel_we;
            lat_mis   <= ~sel_aligned;
            gnt0      <= (pick_winner == PORT_CPU);
            gnt1      <= (pick_winner == PORT_DMA);
            mem_en    <= sel_aligned;
            mem_we    <= sel_we & sel_aligned;
            mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= sel_wdata;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          done0 <= (port == PORT_CPU);
          done1 <= (port == PORT_DMA);
          err   <= lat_mis;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory read data is only valid in RESP of an aligned read; otherwise return zero.
  always_comb begin
    rdata = '0;
    if (state == RESP && !lat_we && !lat_mis) rdata = mem_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a big-endian 32-byte memory model.
// Single transactions are table-driven; contention, back-to-back and reset cases are hand sequenced.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [7:0]  mem [32];
  logic        init_req;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Big-endian byte memory: lowest address holds bits 31:24.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h40 + i);
      mem[8]  <= 8'h12;
      mem[9]  <= 8'h34;
      mem[10] <= 8'h56;
      mem[11] <= 8'h78;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[int'(mem_addr)]     <= mem_wdata[31:24];
        mem[int'(mem_addr) + 1] <= mem_wdata[23:16];
        mem[int'(mem_addr) + 2] <= mem_wdata[15:8];
        mem[int'(mem_addr) + 3] <= mem_wdata[7:0];
      end else begin
        mem_rdata <= {mem[int'(mem_addr)], mem[int'(mem_addr) + 1],
                      mem[int'(mem_addr) + 2], mem[int'(mem_addr) + 3]};
      end
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exp_mem_en;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] cont_exp[10];

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [4:0] addr, input logic [31:0] wdata);
    if (port) begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 5'd8,  32'h0,        1'b1, 1'b0, 32'h12345678};
    vecs[1] = '{1'b1, 1'b1, 5'd4,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 5'd4,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 5'd6,  32'h0,        1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 5'd13, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 5'd12, 32'h0,        1'b1, 1'b0, 32'h4C4D4E4F};
    vecs[6] = '{1'b0, 1'b1, 5'd28, 32'h01020304, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 5'd28, 32'h0,        1'b1, 1'b0, 32'h01020304};
    // {done1, done0, gnt1, gnt0} after each edge with both ports requesting
    cont_exp = '{4'b0001, 4'b0100, 4'b0010, 4'b1000,
                 4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0000, 4'b0000};

    rst_n = 1'b0; init_req = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step(); step();
    init_req = 1'b0;
    check("reset_pulses", {28'h0, done1, done0, gnt1, gnt0}, 32'h0);
    check("reset_mem_ctl", {30'h0, mem_en, mem_we}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_mem_addr", {27'h0, mem_addr}, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    step();

    // Single transactions from IDLE.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].port, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      step();
      check($sformatf("v%0d_gnt", i), {30'h0, gnt1, gnt0}, vecs[i].port ? 32'd2 : 32'd1);
      check($sformatf("v%0d_mem_en", i), {31'h0, mem_en}, {31'h0, vecs[i].exp_mem_en});
      if (vecs[i].exp_mem_en) begin
        check($sformatf("v%0d_mem_addr", i), {27'h0, mem_addr}, {27'h0, vecs[i].addr});
        check($sformatf("v%0d_mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].we});
      end
      drive(vecs[i].port, 1'b0, 1'b0, 5'd0, 32'h0);
      step();
      check($sformatf("v%0d_done", i), {28'h0, done1, done0, gnt1, gnt0},
            vecs[i].port ? 32'h8 : 32'h4);
      check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      step();
      check($sformatf("v%0d_idle", i), {28'h0, done1, done0, gnt1, gnt0}, 32'h0);
    end
    check("write_bytes_4_7", mem_word(4), 32'hDEADBEEF);
    check("misaligned_no_write_12", mem_word(12), 32'h4C4D4E4F);

    // Back-to-back on port 0: next grant directly out of RESP.
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    step();
    check("b2b_gnt_a", {30'h0, gnt1, gnt0}, 32'd1);
    check("b2b_addr_a", {27'h0, mem_addr}, 32'd0);
    addr0 = 5'd16;
    step();
    check("b2b_done_a", {28'h0, done1, done0, gnt1, gnt0}, 32'h4);
    check("b2b_rdata_a", rdata, 32'h40414243);
    step();
    check("b2b_gnt_b", {30'h0, gnt1, gnt0}, 32'd1);
    check("b2b_addr_b", {27'h0, mem_addr}, 32'd16);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("b2b_done_b", {28'h0, done1, done0, gnt1, gnt0}, 32'h4);
    check("b2b_rdata_b", rdata, 32'h50515253);
    step();
    check("b2b_idle", {28'h0, done1, done0, gnt1, gnt0}, 32'h0);

    // Contention: both ports held high across reset release.
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 5'd16, 32'h0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("cont_c%0d", k + 1), {28'h0, done1, done0, gnt1, gnt0},
            {28'h0, cont_exp[k]});
      if (done0) check($sformatf("cont_rdata0_c%0d", k + 1), rdata, 32'h40414243);
      if (done1) check($sformatf("cont_rdata1_c%0d", k + 1), rdata, 32'h50515253);
      if (k == 7) begin
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      end
    end

    // Reset during ACCESS of a write abandons it.
    drive(1'b1, 1'b1, 1'b1, 5'd12, 32'hCAFEF00D);
    step();
    check("rst_gnt1", {30'h0, gnt1, gnt0}, 32'd2);
    check("rst_mem_en_before", {31'h0, mem_en}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mem_en_async", {31'h0, mem_en}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("rst_no_done", {28'h0, done1, done0, gnt1, gnt0}, 32'h0);
    check("rst_bytes_12_15", mem_word(12), 32'h4C4D4E4F);
    rst_n = 1'b1;
    step();
    check("rst_quiet_1", {28'h0, done1, done0, gnt1, gnt0}, 32'h0);
    step();
    check("rst_quiet_2", {28'h0, done1, done0, gnt1, gnt0}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 5'd16, 32'h0);
    step();
    check("rst_tie_port0", {30'h0, gnt1, gnt0}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("rst_tie_done0", {28'h0, done1, done0, gnt1, gnt0}, 32'h4);
    check("rst_tie_rdata", rdata, 32'h40414243);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
